apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Per-core APB master that converts a single-outstanding load/store request from the vmicro16 core memory stage into a compliant two-phase APB transfer (SETUP then ACCESS). It drives one master slot of the APB interconnect's S_* inputs. It returns read data, or a timeout error, to the core as a one-cycle response pulse. One instance per core; the interconnect concatenates instances into its MASTER_PORTS-wide buses.

## Interface
Parameters:
- BUS_WIDTH, 16, address width
- DATA_WIDTH, 16, data width
- TIMEOUT, `DEF_APB_TIMEOUT` (255), max ACCESS cycles without PREADY before error; 0 disables timeout

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  bridge can accept; high exactly when state is IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  BUS_WIDTH  request address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout
- M_PADDR  out  BUS_WIDTH  APB address
- M_PWRITE  out  1  APB write
- M_PSELx  out  1  APB select
- M_PENABLE  out  1  APB enable
- M_PWDATA  out  DATA_WIDTH  APB write data
- M_PRDATA  in  DATA_WIDTH  read data routed back by the interconnect
- M_PREADY  in  1  ready routed back by the interconnect

## Operation
- FSM: IDLE, SETUP, ACCESS. Reset state is IDLE.
- IDLE: req_valid & req_ready accepts the request and latches addr, write and wdata into M_PADDR, M_PWRITE and M_PWDATA. Next state is SETUP.
- SETUP: M_PSELx=1, M_PENABLE=0. Stays exactly one cycle, then goes to ACCESS. Clears the timeout counter.
- ACCESS: M_PSELx=1, M_PENABLE=1.
  - M_PREADY=1: capture M_PRDATA when the transfer is a read; go to IDLE; rsp_valid=1 in the next cycle.
  - M_PREADY=0: increment the timeout counter. When TIMEOUT≠0 and the count reaches TIMEOUT, go to IDLE with rsp_err=1 and rsp_rdata=0.
- M_PREADY and M_PRDATA are ignored outside ACCESS. This covers PREADY asserted while another master owns the interconnect.
- M_PADDR, M_PWRITE and M_PWDATA stay stable from SETUP through ACCESS and hold their last value in IDLE.
- Timeout counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

## Timing
- Reset values: M_PSELx=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1, because state is IDLE.
- A request presented while reset is high is not accepted.
- All outputs except req_ready are registered. req_ready is decoded from state.
- Latency with zero-wait slave:
  - cycle 0: accept (IDLE)
  - cycle 1: SETUP
  - cycle 2: ACCESS, PREADY=1
  - cycle 3: rsp_valid
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Back-to-back: the state is IDLE during the rsp_valid cycle, so a new request may be accepted in that cycle. Sustained throughput is one transfer per 3 cycles.
- rsp_rdata and rsp_err are valid only while rsp_valid=1. They return to 0 the cycle after.
- Reset mid-transfer, asynchronous:
  - M_PSELx and M_PENABLE drop immediately.
  - No rsp_valid is issued for the aborted transfer.
- The interconnect gates PENABLE with the previous cycle's select, so the SETUP cycle must always be emitted. Do not shortcut IDLE directly to ACCESS.

## Structure
- `DEF_APB_TIMEOUT` is added to vmicro16_soc_config.v next to the other APB defines. The clog2 macro comes from clog2.v.
- FSM state encodings are localparams inside the module; they are not shared.
- No sub-module. The timeout counter is inline.

## Test plan
- Read, zero-wait slave: req addr=0x0010, write=0; PREADY=1 on first ACCESS with PRDATA=0xBEEF. Expect:
  - PSEL=1, PENABLE=0 for one cycle, then PSEL=1, PENABLE=1 for one cycle;
  - rsp_valid at cycle 3 with rdata=0xBEEF, err=0.
- Write, 2 wait states: addr=0x0020, wdata=0x1234; PREADY low for 2 ACCESS cycles. Expect:
  - PADDR and PWDATA stable for 4 cycles;
  - rsp_valid at cycle 5 with rdata=0, err=0.
- Timeout with TIMEOUT=4, PREADY held 0. Expect exactly one rsp_valid with err=1 and rdata=0, then PSEL=0 and req_ready=1.
- Back-to-back: a second request is held on req_valid while the first response returns. Expect:
  - accepted in the rsp_valid cycle;
  - second SETUP on the following cycle.
- Stray PREADY=1 during IDLE and SETUP. Expect no response and no early transition to IDLE.
- Reset asserted during ACCESS. Expect:
  - PSEL and PENABLE = 0 in the same cycle;
  - no rsp_valid;
  - req_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared constants and helpers for the per-core APB master bridge
package apb_master_bridge_pkg;

    // Default number of PREADY-low ACCESS cycles tolerated before a transfer errors out.
    localparam int DEF_APB_TIMEOUT = 255;

    // Bits needed to hold values 0..max_count; never less than one so a
    // disabled timeout (0) still yields a legal vector.
    function automatic int cnt_width(input int max_count);
        int w;
        w = 1;
        while ((1 << w) < (max_count + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding core load/store to two-phase APB master
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready        core request handshake (ready == state IDLE)
//   req_write/req_addr/req_wdata  request attributes, latched on accept
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response pulse; rdata 0 on writes and errors
//   M_PADDR/M_PWRITE/M_PWDATA  APB request attributes, held stable until the next accept
//   M_PSELx/M_PENABLE          APB phase control (SETUP: 1/0, ACCESS: 1/1)
//   M_PRDATA/M_PREADY          slave response routed back by the interconnect
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = DEF_APB_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [BUS_WIDTH-1:0]  M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;

    assign req_ready = (state == ST_IDLE);

    // The current PREADY-low ACCESS cycle is the TIMEOUT-th one.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = ((int'(to_cnt) + 1) >= TIMEOUT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SETUP is never skipped: the interconnect qualifies PENABLE with the
    // previous cycle's select.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_valid) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: if (M_PREADY || timeout_hit) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Registered outputs. PSEL/PENABLE are derived from next_state so they
    // line up with the state register while still coming straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PADDR   <= '0;
            M_PWRITE  <= 1'b0;
            M_PWDATA  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            M_PSELx   <= (next_state != ST_IDLE);
            M_PENABLE <= (next_state == ST_ACCESS);
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        M_PADDR  <= req_addr;
                        M_PWRITE <= req_write;
                        M_PWDATA <= req_wdata;
                    end
                end
                ST_SETUP: begin
                    to_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (M_PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= M_PWRITE ? '0 : M_PRDATA;
                    end else begin
                        if (to_cnt != CNT_MAX) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        if (timeout_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a randomized APB slave
module tb_apb_master_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] M_PADDR;
    logic        M_PWRITE;
    logic        M_PSELx;
    logic        M_PENABLE;
    logic [15:0] M_PWDATA;
    logic [15:0] M_PRDATA = '0;
    logic        M_PREADY = 1'b0;

    always #5 clk = ~clk;

    apb_master_bridge #(.BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
        .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
        .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          a_cyc;
        int          rsp_cyc;
    } txn_t;

    txn_t        exp_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    bit          mon_en = 0;
    int          cur_waits = 0;
    logic [15:0] cur_rdata = '0;
    int          prev_rsp = 0;
    logic [15:0] hold_addr = '0;
    logic [15:0] hold_wdata = '0;
    logic        hold_wr = 1'b0;
    bit          m_active;
    bit          m_acc;
    int          acc_k = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave: after `cur_waits` low ACCESS cycles it answers; outside ACCESS it
    // drives stray PREADY/PRDATA noise that the bridge must ignore.
    initial forever begin
        @(negedge clk);
        if (M_PSELx && M_PENABLE) begin
            M_PREADY = (acc_k >= cur_waits);
            M_PRDATA = M_PREADY ? cur_rdata : 16'($urandom);
            acc_k++;
        end else begin
            acc_k = 0;
            M_PREADY = 1'($urandom_range(0, 1));
            M_PRDATA = 16'($urandom);
        end
    end

    // Monitor: response and bus phase expectations derived from the head transaction.
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].rsp_cyc == cyc) begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                check("rsp_err", rsp_err, exp_q[0].err);
                hold_addr  = exp_q[0].addr;
                hold_wdata = exp_q[0].wdata;
                hold_wr    = exp_q[0].wr;
                void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_quiet", rsp_valid, 0);
                check("rsp_fields_quiet", {rsp_err, rsp_rdata}, 0);
            end
            m_active = (exp_q.size() > 0) && (cyc > exp_q[0].a_cyc) && (cyc < exp_q[0].rsp_cyc);
            m_acc    = m_active && (cyc > exp_q[0].a_cyc + 1);
            check("psel", M_PSELx, m_active);
            check("penable", M_PENABLE, m_acc);
            check("req_ready", req_ready, !m_active);
            if (m_active) begin
                check("paddr", M_PADDR, exp_q[0].addr);
                check("pwrite", M_PWRITE, exp_q[0].wr);
                check("pwdata", M_PWDATA, exp_q[0].wdata);
            end else begin
                check("paddr_hold", {M_PWRITE, M_PWDATA, M_PADDR}, {hold_wr, hold_wdata, hold_addr});
            end
        end
    end

    // Expected behaviour: accepted when IDLE (max of presentation and previous
    // response cycle); response one cycle after the deciding ACCESS cycle, which
    // is the (waits+1)-th ACCESS cycle, or the T-th when waits >= T.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int waits, input int gap);
        txn_t t;
        int   pres;
        int   n;
        repeat (gap) @(negedge clk);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        pres = cyc;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        check("accept_cycle", 32'(cyc), 32'((prev_rsp > pres) ? prev_rsp : pres));
        t.wr      = wr;
        t.addr    = addr;
        t.wdata   = wdata;
        t.err     = (waits >= T);
        t.rdata   = (t.err || wr) ? 16'h0 : rdata;
        t.a_cyc   = cyc;
        t.rsp_cyc = cyc + 3 + ((waits < T) ? waits : T - 1);
        prev_rsp  = t.rsp_cyc;
        cur_waits = waits;
        cur_rdata = rdata;
        exp_q.push_back(t);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'hAAAA;
        req_wdata = 16'h5555;
        repeat (3) @(negedge clk);
        check("reset_psel_penable", {M_PSELx, M_PENABLE}, 0);
        check("reset_bus", {M_PWRITE, M_PWDATA, M_PADDR}, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_req_ready", req_ready, 1);
        reset = 1'b0;
        req_valid = 1'b0;
        mon_en = 1;

        issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);
        issue(1'b1, 16'h0020, 16'h1234, 16'h0000, 2, 2);
        issue(1'b0, 16'h0030, 16'h0000, 16'h7777, 9, 2);
        issue(1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1, 2);
        issue(1'b1, 16'h0042, 16'hA5A5, 16'h0000, 0, 0);
        issue(1'b0, 16'h0044, 16'h0000, 16'h0F0F, 3, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
        end
        drain();

        issue(1'b0, 16'h0050, 16'h0000, 16'h1111, 20, 1);
        n = 0;
        while (!(M_PSELx && M_PENABLE) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_access", {M_PSELx, M_PENABLE}, 2'b11);
        #3;
        reset = 1'b1;
        exp_q.delete();
        hold_addr  = '0;
        hold_wdata = '0;
        hold_wr    = 1'b0;
        prev_rsp   = 0;
        #1;
        check("abort_psel_drop", {M_PSELx, M_PENABLE}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        repeat (8) @(negedge clk);
        issue(1'b0, 16'h0060, 16'h0000, 16'h2222, 0, 0);
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
